// File: rtl/wts_wave_memory_arbiter_pkg.sv
// Shared types and constants for the wave RAM arbiter: request modes,
// RAM geometry, the SCC channel 3/4 mirror pair and the arbiter FSM states.
package wts_wave_pkg;

    localparam int CH_NUM        = 10;
    localparam int IDX_W         = 7;
    localparam int CH_W          = 4;
    localparam int AW            = CH_W + IDX_W;
    localparam int SCC_IDX_W     = 5;
    localparam int MIRROR_SRC_CH = 3;
    localparam int MIRROR_DST_CH = 4;

    typedef enum logic [1:0] {
        MODE_SCC  = 2'd0,
        MODE_SCCI = 2'd1,
        MODE_WTS  = 2'd2
    } mode_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MIRROR = 1'b1
    } state_t;

    // SCC and SCC-I only expose 32 samples per channel; mode 3 behaves as WTS.
    function automatic logic is_scc_family(input logic [1:0] mode);
        return (mode == MODE_SCC) || (mode == MODE_SCCI);
    endfunction

endpackage

// File: rtl/wts_wave_memory_arbiter_if.sv
// CPU request port, sound fetch port and wave RAM port of the arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface wts_wave_memory_arbiter_if;
    import wts_wave_pkg::*;

    logic             cpu_valid;
    logic             cpu_ready;
    logic             cpu_write;
    logic [1:0]       cpu_mode;
    logic [CH_W-1:0]  cpu_ch;
    logic [IDX_W-1:0] cpu_idx;
    logic [7:0]       cpu_wdata;
    logic [7:0]       cpu_rdata;
    logic             cpu_rdata_valid;

    logic             snd_valid;
    logic             snd_ready;
    logic [CH_W-1:0]  snd_ch;
    logic [IDX_W-1:0] snd_idx;
    logic [7:0]       snd_rdata;
    logic             snd_rdata_valid;

    logic             ram_ce;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [7:0]       ram_wdata;
    logic [7:0]       ram_rdata;

    modport slave (
        input  cpu_valid, cpu_write, cpu_mode, cpu_ch, cpu_idx, cpu_wdata,
        input  snd_valid, snd_ch, snd_idx, ram_rdata,
        output cpu_ready, cpu_rdata, cpu_rdata_valid,
        output snd_ready, snd_rdata, snd_rdata_valid,
        output ram_ce, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_valid, cpu_write, cpu_mode, cpu_ch, cpu_idx, cpu_wdata,
        output snd_valid, snd_ch, snd_idx, ram_rdata,
        input  cpu_ready, cpu_rdata, cpu_rdata_valid,
        input  snd_ready, snd_rdata, snd_rdata_valid,
        input  ram_ce, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/wts_wave_memory_arbiter_addr_map.sv
// Combinational mapping of a (mode, channel, index) request onto the wave RAM
// address, flagging writes that must be dropped and out-of-range reads.
module wts_wave_addr_map
    import wts_wave_pkg::*;
(
    input  logic [1:0]       i_mode,
    input  logic [CH_W-1:0]  i_ch,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_is_cpu,
    output logic [AW-1:0]    o_addr,
    output logic             o_drop,
    output logic             o_oob_read
);

    logic             w_oob;
    logic             w_scc_ch4;
    logic [CH_W-1:0]  w_ch;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        w_oob     = (i_ch >= CH_W'(CH_NUM));
        // SCC channel 4 has no storage of its own: it shadows channel 3.
        w_scc_ch4 = i_is_cpu && (i_mode == MODE_SCC) && (i_ch == CH_W'(MIRROR_DST_CH));
        w_idx     = i_idx;
        if (i_is_cpu && is_scc_family(i_mode)) begin
            w_idx[IDX_W-1:SCC_IDX_W] = '0;
        end
        w_ch       = w_scc_ch4 ? CH_W'(MIRROR_SRC_CH) : i_ch;
        o_addr     = {w_ch, w_idx};
        o_drop     = w_oob || w_scc_ch4;
        o_oob_read = w_oob;
    end

endmodule

// File: rtl/wts_wave_memory_arbiter.sv
// Arbitrates the single-port wave RAM between the slot-bus CPU and the sound
// fetcher, with alternating priority and the SCC channel 3 -> 4 mirror write.
module wts_wave_memory_arbiter
    import wts_wave_pkg::*;
(
    input  logic                      clk,
    input  logic                      nreset,
    wts_wave_memory_arbiter_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_cpu;
    logic [IDX_W-1:0] r_mirror_idx;
    logic [7:0]       r_mirror_data;

    logic             r_ram_ce, r_ram_we;
    logic [AW-1:0]    r_ram_addr;
    logic [7:0]       r_ram_wdata;
    logic             w_ram_ce_next, w_ram_we_next;
    logic [AW-1:0]    w_ram_addr_next;
    logic [7:0]       w_ram_wdata_next;

    logic             r_p1_cpu, r_p1_snd, r_p1_oob;
    logic             r_p2_cpu, r_p2_snd, r_p2_oob;
    logic             w_p1_cpu_next, w_p1_snd_next, w_p1_oob_next;
    logic [7:0]       r_cpu_rdata, r_snd_rdata;
    logic             r_cpu_rdata_valid, r_snd_rdata_valid;

    logic             w_cpu_grant, w_snd_grant, w_mirror_start;
    logic [AW-1:0]    w_cpu_addr, w_snd_addr;
    logic             w_cpu_drop, w_cpu_oob, w_snd_drop, w_snd_oob;

    wts_wave_addr_map u_cpu_map (
        .i_mode     (bus.cpu_mode),
        .i_ch       (bus.cpu_ch),
        .i_idx      (bus.cpu_idx),
        .i_is_cpu   (1'b1),
        .o_addr     (w_cpu_addr),
        .o_drop     (w_cpu_drop),
        .o_oob_read (w_cpu_oob)
    );

    wts_wave_addr_map u_snd_map (
        .i_mode     (2'(MODE_WTS)),
        .i_ch       (bus.snd_ch),
        .i_idx      (bus.snd_idx),
        .i_is_cpu   (1'b0),
        .o_addr     (w_snd_addr),
        .o_drop     (w_snd_drop),
        .o_oob_read (w_snd_oob)
    );

    always_comb begin
        w_state_next     = r_state;
        w_cpu_grant      = 1'b0;
        w_snd_grant      = 1'b0;
        w_mirror_start   = 1'b0;
        w_ram_ce_next    = 1'b0;
        w_ram_we_next    = 1'b0;
        w_ram_addr_next  = r_ram_addr;
        w_ram_wdata_next = r_ram_wdata;
        w_p1_cpu_next    = 1'b0;
        w_p1_snd_next    = 1'b0;
        w_p1_oob_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On contention the side that lost last time wins this time.
                if (bus.cpu_valid && !(bus.snd_valid && r_last_cpu)) begin
                    w_cpu_grant = 1'b1;
                end else if (bus.snd_valid) begin
                    w_snd_grant = 1'b1;
                end
                if (w_cpu_grant) begin
                    if (bus.cpu_write) begin
                        if (!w_cpu_drop) begin
                            w_ram_ce_next    = 1'b1;
                            w_ram_we_next    = 1'b1;
                            w_ram_addr_next  = w_cpu_addr;
                            w_ram_wdata_next = bus.cpu_wdata;
                        end
                        if ((bus.cpu_mode == MODE_SCC) && (bus.cpu_ch == CH_W'(MIRROR_SRC_CH))) begin
                            w_mirror_start = 1'b1;
                            w_state_next   = ST_MIRROR;
                        end
                    end else begin
                        w_p1_cpu_next = 1'b1;
                        w_p1_oob_next = w_cpu_oob;
                        if (!w_cpu_oob) begin
                            w_ram_ce_next   = 1'b1;
                            w_ram_addr_next = w_cpu_addr;
                        end
                    end
                end else if (w_snd_grant) begin
                    w_p1_snd_next = 1'b1;
                    w_p1_oob_next = w_snd_oob;
                    if (!w_snd_drop) begin
                        w_ram_ce_next   = 1'b1;
                        w_ram_addr_next = w_snd_addr;
                    end
                end
            end
            ST_MIRROR: begin
                w_ram_ce_next    = 1'b1;
                w_ram_we_next    = 1'b1;
                w_ram_addr_next  = {CH_W'(MIRROR_DST_CH), r_mirror_idx};
                w_ram_wdata_next = r_mirror_data;
                w_state_next     = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state           <= ST_IDLE;
            r_last_cpu        <= 1'b0;
            r_mirror_idx      <= '0;
            r_mirror_data     <= '0;
            r_ram_ce          <= 1'b0;
            r_ram_we          <= 1'b0;
            r_ram_addr        <= '0;
            r_ram_wdata       <= '0;
            r_p1_cpu          <= 1'b0;
            r_p1_snd          <= 1'b0;
            r_p1_oob          <= 1'b0;
            r_p2_cpu          <= 1'b0;
            r_p2_snd          <= 1'b0;
            r_p2_oob          <= 1'b0;
            r_cpu_rdata       <= '0;
            r_snd_rdata       <= '0;
            r_cpu_rdata_valid <= 1'b0;
            r_snd_rdata_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_cpu_grant) begin
                r_last_cpu <= 1'b1;
            end else if (w_snd_grant) begin
                r_last_cpu <= 1'b0;
            end
            if (w_mirror_start) begin
                r_mirror_idx  <= w_cpu_addr[IDX_W-1:0];
                r_mirror_data <= bus.cpu_wdata;
            end
            r_ram_ce    <= w_ram_ce_next;
            r_ram_we    <= w_ram_we_next;
            r_ram_addr  <= w_ram_addr_next;
            r_ram_wdata <= w_ram_wdata_next;
            // Stage 1 tracks the RAM access cycle, stage 2 the data-return cycle.
            r_p1_cpu <= w_p1_cpu_next;
            r_p1_snd <= w_p1_snd_next;
            r_p1_oob <= w_p1_oob_next;
            r_p2_cpu <= r_p1_cpu;
            r_p2_snd <= r_p1_snd;
            r_p2_oob <= r_p1_oob;
            r_cpu_rdata_valid <= r_p2_cpu;
            r_snd_rdata_valid <= r_p2_snd;
            if (r_p2_cpu) begin
                r_cpu_rdata <= r_p2_oob ? 8'hFF : bus.ram_rdata;
            end
            if (r_p2_snd) begin
                r_snd_rdata <= r_p2_oob ? 8'h00 : bus.ram_rdata;
            end
        end
    end

    assign bus.cpu_ready       = w_cpu_grant;
    assign bus.snd_ready       = w_snd_grant;
    assign bus.ram_ce          = r_ram_ce;
    assign bus.ram_we          = r_ram_we;
    assign bus.ram_addr        = r_ram_addr;
    assign bus.ram_wdata       = r_ram_wdata;
    assign bus.cpu_rdata       = r_cpu_rdata;
    assign bus.cpu_rdata_valid = r_cpu_rdata_valid;
    assign bus.snd_rdata       = r_snd_rdata;
    assign bus.snd_rdata_valid = r_snd_rdata_valid;

endmodule

// File: tb/tb_wts_wave_memory_arbiter.sv
// Self-checking bench for wts_wave_memory_arbiter: directed scenarios plus a
// randomized contention phase, checked against a per-channel wave memory model.
module tb_wts_wave_memory_arbiter;
    import wts_wave_pkg::*;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    wts_wave_memory_arbiter_if bus ();

    wts_wave_memory_arbiter dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    // Write-first single-port RAM with registered read.
    logic [7:0] ram_mem [0:(1<<AW)-1] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.ram_ce) begin
            if (bus.ram_we) begin
                ram_mem[bus.ram_addr] <= bus.ram_wdata;
                bus.ram_rdata         <= bus.ram_wdata;
            end else begin
                bus.ram_rdata <= ram_mem[bus.ram_addr];
            end
        end
    end

    // Reference model: the wave contents seen per channel and sample.
    logic [7:0] gold [0:15][0:127];
    typedef struct { int due; logic [7:0] data; } rd_t;
    rd_t cpu_q[$];
    rd_t snd_q[$];

    int n_total = 0, n_pass = 0, n_fail = 0, cyc = 0, snd_wait = 0;
    bit exp_ce, exp_we, mirror_now, mirror_next, m_last_cpu, cpu_hs, snd_hs;
    logic [AW-1:0] exp_addr, mirror_addr;
    logic [7:0] exp_wd, mirror_data, last_cpu_rd, last_snd_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict readies and effects, cross the edge, check outputs.
    task automatic step();
        bit er_cpu, er_snd, oob, scc, ev;
        logic [3:0] ch, rch;
        logic [6:0] eidx;
        #2;
        if (mirror_now) begin
            er_cpu = 1'b0; er_snd = 1'b0;
        end else if (bus.cpu_valid && bus.snd_valid) begin
            er_cpu = !m_last_cpu; er_snd = m_last_cpu;
        end else begin
            er_cpu = bus.cpu_valid; er_snd = bus.snd_valid;
        end
        chk("cpu_ready", bus.cpu_ready, er_cpu);
        chk("snd_ready", bus.snd_ready, er_snd);
        cpu_hs = bus.cpu_valid && bus.cpu_ready;
        snd_hs = bus.snd_valid && bus.snd_ready && !cpu_hs;
        exp_ce = 1'b0; exp_we = 1'b0; mirror_next = 1'b0;
        if (mirror_now) begin
            exp_ce = 1'b1; exp_we = 1'b1; exp_addr = mirror_addr; exp_wd = mirror_data;
        end
        if (bus.snd_valid) snd_wait++;
        if (cpu_hs) begin
            ch   = bus.cpu_ch;
            oob  = (ch >= 4'd10);
            scc  = (bus.cpu_mode == 2'd0);
            eidx = (bus.cpu_mode <= 2'd1) ? {2'b00, bus.cpu_idx[4:0]} : bus.cpu_idx;
            $display("cyc %0d cpu %s mode=%0d ch=%0d idx=%0d wdata=%02h", cyc + 1,
                     bus.cpu_write ? "wr" : "rd", bus.cpu_mode, ch, bus.cpu_idx, bus.cpu_wdata);
            if (bus.cpu_write) begin
                if (!oob && !(scc && ch == 4'd4)) begin
                    gold[ch][eidx] = bus.cpu_wdata;
                    exp_ce = 1'b1; exp_we = 1'b1; exp_addr = {ch, eidx}; exp_wd = bus.cpu_wdata;
                    if (scc && ch == 4'd3) begin
                        gold[4][eidx] = bus.cpu_wdata;
                        mirror_next = 1'b1; mirror_addr = {4'd4, eidx}; mirror_data = bus.cpu_wdata;
                    end
                end
            end else if (oob) begin
                cpu_q.push_back('{cyc + 3, 8'hFF});
            end else begin
                rch = (scc && ch == 4'd4) ? 4'd3 : ch;
                cpu_q.push_back('{cyc + 3, gold[rch][eidx]});
                exp_ce = 1'b1; exp_addr = {rch, eidx};
            end
            m_last_cpu = 1'b1;
        end else if (snd_hs) begin
            ch = bus.snd_ch;
            $display("cyc %0d snd rd ch=%0d idx=%0d", cyc + 1, ch, bus.snd_idx);
            chk("snd_wait_le3", snd_wait <= 3, 1'b1);
            snd_wait = 0;
            if (ch >= 4'd10) begin
                snd_q.push_back('{cyc + 3, 8'h00});
            end else begin
                snd_q.push_back('{cyc + 3, gold[ch][bus.snd_idx]});
                exp_ce = 1'b1; exp_addr = {ch, bus.snd_idx};
            end
            m_last_cpu = 1'b0;
        end
        @(posedge clk);
        cyc++;
        mirror_now = mirror_next;
        #1;
        chk("ram_ce", bus.ram_ce, exp_ce);
        chk("ram_we", bus.ram_we, exp_we);
        if (exp_ce) chk("ram_addr", bus.ram_addr, exp_addr);
        if (exp_ce && exp_we) chk("ram_wdata", bus.ram_wdata, exp_wd);
        ev = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
        chk("cpu_rdata_valid", bus.cpu_rdata_valid, ev);
        if (ev) begin
            chk("cpu_rdata", bus.cpu_rdata, cpu_q[0].data);
            last_cpu_rd = bus.cpu_rdata;
            void'(cpu_q.pop_front());
        end
        ev = (snd_q.size() > 0) && (snd_q[0].due == cyc);
        chk("snd_rdata_valid", bus.snd_rdata_valid, ev);
        if (ev) begin
            chk("snd_rdata", bus.snd_rdata, snd_q[0].data);
            last_snd_rd = bus.snd_rdata;
            void'(snd_q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cpu_req(input bit w, input logic [1:0] m, input logic [3:0] ch,
                           input logic [6:0] idx, input logic [7:0] d);
        int n = 0;
        bus.cpu_valid = 1'b1; bus.cpu_write = w; bus.cpu_mode = m;
        bus.cpu_ch = ch; bus.cpu_idx = idx; bus.cpu_wdata = d;
        do begin step(); n++; end while (!cpu_hs && n < 20);
        chk("cpu_handshake_timeout", cpu_hs, 1'b1);
        bus.cpu_valid = 1'b0;
    endtask

    task automatic snd_req(input logic [3:0] ch, input logic [6:0] idx);
        int n = 0;
        bus.snd_valid = 1'b1; bus.snd_ch = ch; bus.snd_idx = idx;
        do begin step(); n++; end while (!snd_hs && n < 20);
        chk("snd_handshake_timeout", snd_hs, 1'b1);
        bus.snd_valid = 1'b0;
    endtask

    task automatic rand_cpu();
        if ($urandom_range(0, 3) == 0) begin
            bus.cpu_mode = 2'd0; bus.cpu_ch = 4'd3; bus.cpu_write = 1'b1;
        end else begin
            bus.cpu_mode = 2'($urandom_range(0, 3));
            bus.cpu_ch = 4'($urandom_range(0, 11));
            bus.cpu_write = 1'($urandom_range(0, 1));
        end
        bus.cpu_idx = 7'($urandom);
        bus.cpu_wdata = 8'($urandom);
    endtask

    task automatic rand_snd();
        bus.snd_ch = 4'($urandom_range(0, 10));
        bus.snd_idx = 7'($urandom);
    endtask

    initial begin
        for (int c = 0; c < 16; c++)
            for (int i = 0; i < 128; i++) gold[c][i] = 8'h00;
        bus.cpu_valid = 1'b0; bus.cpu_write = 1'b0; bus.cpu_mode = 2'd0;
        bus.cpu_ch = 4'd0; bus.cpu_idx = 7'd0; bus.cpu_wdata = 8'd0;
        bus.snd_valid = 1'b0; bus.snd_ch = 4'd0; bus.snd_idx = 7'd0;
        last_cpu_rd = 8'h00; last_snd_rd = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_ce", bus.ram_ce, 1'b0);
        chk("rst_ram_we", bus.ram_we, 1'b0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_snd_rdata", bus.snd_rdata, 0);
        chk("rst_cpu_rvalid", bus.cpu_rdata_valid, 1'b0);
        chk("rst_snd_rvalid", bus.snd_rdata_valid, 1'b0);
        nreset = 1'b1;

        // WTS write/read at the top corner of the RAM.
        cpu_req(1'b1, 2'd2, 4'd9, 7'd127, 8'h5A);
        chk("wts_wr_addr", bus.ram_addr, 11'h4FF);
        cpu_req(1'b0, 2'd2, 4'd9, 7'd127, 8'h00);
        idle(3);
        chk("wts_readback", last_cpu_rd, 8'h5A);

        // SCC channel 3 write mirrored into channel 4.
        cpu_req(1'b1, 2'd0, 4'd3, 7'd37, 8'h33);
        chk("mirror_src_addr", bus.ram_addr, {4'd3, 7'd5});
        step();
        chk("mirror_dst_addr", bus.ram_addr, {4'd4, 7'd5});
        chk("mirror_dst_we", bus.ram_we, 1'b1);
        snd_req(4'd4, 7'd5);
        idle(3);
        chk("mirror_fetch", last_snd_rd, 8'h33);

        // Out-of-range and dropped requests.
        cpu_req(1'b0, 2'd2, 4'd12, 7'd0, 8'h00);
        chk("oob_rd_no_ce", bus.ram_ce, 1'b0);
        idle(3);
        chk("oob_rd_ff", last_cpu_rd, 8'hFF);
        cpu_req(1'b1, 2'd2, 4'd12, 7'd1, 8'h99);
        chk("oob_wr_no_ce", bus.ram_ce, 1'b0);
        cpu_req(1'b1, 2'd0, 4'd4, 7'd5, 8'h77);
        chk("scc_ch4_wr_no_ce", bus.ram_ce, 1'b0);
        snd_req(4'd4, 7'd5);
        idle(3);
        chk("ch4_unchanged", last_snd_rd, 8'h33);
        snd_req(4'd11, 7'd3);
        idle(3);
        chk("snd_oob_zero", last_snd_rd, 8'h00);

        // Write then immediate read of the same address, also via SCC-I masking.
        cpu_req(1'b1, 2'd2, 4'd1, 7'd10, 8'hC3);
        cpu_req(1'b0, 2'd2, 4'd1, 7'd10, 8'h00);
        idle(3);
        chk("wr_then_rd", last_cpu_rd, 8'hC3);
        cpu_req(1'b0, 2'd1, 4'd1, 7'd42, 8'h00);
        idle(3);
        chk("scci_masked_rd", last_cpu_rd, 8'hC3);

        // Contention: both held high first, then random valid gaps.
        rand_cpu(); rand_snd();
        bus.cpu_valid = 1'b1; bus.snd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (cpu_hs) begin
                rand_cpu();
                bus.cpu_valid = (i < 150) ? 1'b1 : 1'($urandom_range(0, 7) != 0);
            end else if (!bus.cpu_valid) begin
                bus.cpu_valid = 1'($urandom_range(0, 1));
            end
            if (snd_hs) begin
                rand_snd();
                bus.snd_valid = (i < 150) ? 1'b1 : 1'($urandom_range(0, 7) != 0);
            end else if (!bus.snd_valid) begin
                bus.snd_valid = 1'($urandom_range(0, 1));
            end
        end
        bus.cpu_valid = 1'b0; bus.snd_valid = 1'b0;
        idle(4);
        snd_wait = 0;

        // Reset one cycle after a read handshake: the read must vanish.
        cpu_req(1'b0, 2'd2, 4'd9, 7'd127, 8'h00);
        step();
        nreset = 1'b0;
        #2;
        chk("mid_rst_ram_ce", bus.ram_ce, 1'b0);
        chk("mid_rst_ram_we", bus.ram_we, 1'b0);
        chk("mid_rst_ram_addr", bus.ram_addr, 0);
        chk("mid_rst_ram_wdata", bus.ram_wdata, 0);
        chk("mid_rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("mid_rst_snd_rdata", bus.snd_rdata, 0);
        cpu_q.delete(); snd_q.delete();
        mirror_now = 1'b0; m_last_cpu = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            chk("mid_rst_cpu_rvalid", bus.cpu_rdata_valid, 1'b0);
        end
        nreset = 1'b1;

        // After release the CPU wins contention again and is served normally.
        bus.snd_valid = 1'b1; bus.snd_ch = 4'd4; bus.snd_idx = 7'd5;
        cpu_req(1'b0, 2'd2, 4'd1, 7'd10, 8'h00);
        begin
            int n = 0;
            while (!snd_hs && n < 10) begin step(); n++; end
            chk("post_rst_snd_timeout", snd_hs, 1'b1);
        end
        bus.snd_valid = 1'b0;
        idle(3);
        chk("post_rst_cpu_rd", last_cpu_rd, 8'hC3);
        chk("post_rst_snd_rd", last_snd_rd, 8'h33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
